// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D cache miss paths, the memory arbiter and main memory.
// slave = arbiter view; master = view of the caches and the memory together.
interface mem_arbiter_if #(
   parameter int AW     = 16,
   parameter int DATA_W = 16
);
   logic              i_req;
   logic [AW-1:0]     i_addr;
   logic              i_stall;
   logic [DATA_W-1:0] i_data;
   logic [AW-1:0]     i_addr_out;
   logic              i_cache_we;

   logic              d_req;
   logic              d_wr;
   logic [AW-1:0]     d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_stall;
   logic [DATA_W-1:0] d_data;
   logic [AW-1:0]     d_addr_out;
   logic              d_cache_we;

   logic              mem_en;
   logic              mem_wr;
   logic [AW-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
      output i_stall, i_data, i_addr_out, i_cache_we,
             d_stall, d_data, d_addr_out, d_cache_we,
             mem_en, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
      input  i_stall, i_data, i_addr_out, i_cache_we,
             d_stall, d_data, d_addr_out, d_cache_we,
             mem_en, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between I-cache fills, D-cache fills and
// D-side write-throughs; block fills are pipelined (issue and receive overlap).
module mem_arbiter #(
   parameter int WORDS   = 8,
   parameter int MEM_LAT = 4,
   parameter int AW      = 16,
   parameter int DATA_W  = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);
   localparam int            CW       = $clog2(WORDS) + 1;
   localparam int            BLK_W    = $clog2(WORDS) + 1;
   localparam logic [CW-1:0] WORDS_C  = CW'(WORDS);
   localparam logic [CW-1:0] LAST_C   = CW'(WORDS - 1);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [AW-1:0] BLK_MASK = ~AW'((1 << BLK_W) - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_IFILL  = 2'd1;
   localparam logic [1:0] S_DFILL  = 2'd2;
   localparam logic [1:0] S_DWRITE = 2'd3;

   if (MEM_LAT < 1 || WORDS < 2) begin : g_bad_param
      $error("mem_arbiter: MEM_LAT must be >= 1 and WORDS >= 2");
   end

   function automatic logic [AW-1:0] f_word_addr(input logic [AW-1:0] base,
                                                 input logic [CW-1:0] idx);
      return base + (AW'(idx) << 1);
   endfunction

   function automatic logic [AW-1:0] f_block_base(input logic [AW-1:0] addr);
      return addr & BLK_MASK;
   endfunction

   logic [1:0]        r_state;
   logic [CW-1:0]     r_issue_cnt;
   logic [CW-1:0]     r_recv_cnt;
   logic              r_last_d;
   logic [AW-1:0]     r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic              w_fill;
   logic              w_issue;
   logic              w_recv;
   logic              w_last;
   logic              w_pick_d;
   logic              w_pick_i;
   logic              w_i_we;
   logic              w_d_we;
   logic [AW-1:0]     w_recv_addr;

   assign w_fill   = (r_state == S_IFILL) || (r_state == S_DFILL);
   assign w_issue  = w_fill && (r_issue_cnt < WORDS_C);
   // Valids outside a fill, or past the last word, are dropped here.
   assign w_recv   = w_fill && bus.mem_valid && (r_recv_cnt < WORDS_C);
   assign w_last   = w_recv && (r_recv_cnt == LAST_C);

   // D wins unless both are pending and D had the previous grant.
   assign w_pick_d = bus.d_req && (!bus.i_req || !r_last_d);
   assign w_pick_i = bus.i_req && !w_pick_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
         r_last_d    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_issue_cnt <= '0;
               r_recv_cnt  <= '0;
               if (w_pick_d) begin
                  r_state  <= bus.d_wr ? S_DWRITE : S_DFILL;
                  r_addr   <= bus.d_wr ? bus.d_addr : f_block_base(bus.d_addr);
                  r_wdata  <= bus.d_wdata;
                  r_last_d <= 1'b1;
               end else if (w_pick_i) begin
                  r_state  <= S_IFILL;
                  r_addr   <= f_block_base(bus.i_addr);
                  r_last_d <= 1'b0;
               end
            end
            S_IFILL, S_DFILL: begin
               if (w_issue) r_issue_cnt <= r_issue_cnt + ONE_C;
               if (w_recv)  r_recv_cnt  <= r_recv_cnt + ONE_C;
               if (w_last)  r_state     <= S_IDLE;
            end
            S_DWRITE: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (r_state == S_DWRITE) begin
         bus.mem_en    = 1'b1;
         bus.mem_wr    = 1'b1;
         bus.mem_addr  = r_addr;
         bus.mem_wdata = r_wdata;
      end else if (w_issue) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = f_word_addr(r_addr, r_issue_cnt);
      end
   end

   // Returned words go only to the side that owns the current fill.
   assign w_i_we      = w_recv && (r_state == S_IFILL);
   assign w_d_we      = w_recv && (r_state == S_DFILL);
   assign w_recv_addr = f_word_addr(r_addr, r_recv_cnt);

   assign bus.i_cache_we = w_i_we;
   assign bus.i_data     = w_i_we ? bus.mem_rdata : '0;
   assign bus.i_addr_out = w_i_we ? w_recv_addr : '0;
   assign bus.d_cache_we = w_d_we;
   assign bus.d_data     = w_d_we ? bus.mem_rdata : '0;
   assign bus.d_addr_out = w_d_we ? w_recv_addr : '0;

   assign bus.i_stall = bus.i_req && !((r_state == S_IFILL) && w_last);
   assign bus.d_stall = bus.d_req && !(((r_state == S_DFILL) && w_last) ||
                                       (r_state == S_DWRITE));
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model; table of
// single-requester transactions plus hand-written fairness/reset/withdraw cases.
module tb_mem_arbiter;
   localparam int WORDS   = 8;
   localparam int MEM_LAT = 4;
   localparam int AW      = 16;
   localparam int DW      = 16;
   localparam int FILL_CYCLES = 1 + WORDS + MEM_LAT;

   typedef struct {
      logic        is_d;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_base;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc;

   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT), .AW(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [15:0] fdat(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C5A;
   endfunction

   // Memory: a read issued in cycle t returns its data in cycle t+MEM_LAT.
   logic [MEM_LAT-1:0] pv = '0;
   logic [15:0]        pa [MEM_LAT];
   always @(posedge clk) begin
      pv <= {pv[MEM_LAT-2:0], (bus.mem_en & ~bus.mem_wr)};
      pa[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
   end
   assign bus.mem_valid = pv[MEM_LAT-1];
   assign bus.mem_rdata = pv[MEM_LAT-1] ? fdat(pa[MEM_LAT-1]) : 16'h0000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Called right after the requests were driven at a negedge (the arbitration cycle).
   task automatic watch_fill(input logic is_d, input logic [15:0] base, input int drop_cyc,
                             input int stop_rcv, output int ncyc);
      int n_iss, n_rcv, fidx;
      logic we, owe, stall, ostall, req, oreq;
      logic [15:0] ea;
      logic [15:0] ao, dat;
      n_iss = 0; n_rcv = 0; fidx = 0; ncyc = 1;
      #1;
      chk("arb_stall", is_d ? bus.d_stall : bus.i_stall, 1);
      chk("arb_mem_en", bus.mem_en, 0);
      while (n_rcv < stop_rcv && fidx < 40) begin
         @(negedge clk);
         if (fidx == drop_cyc) begin
            if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
         end
         #1;
         ncyc++;
         if (bus.mem_en) begin
            chk("issue_wr", bus.mem_wr, 0);
            chk($sformatf("issue_addr%0d", n_iss), bus.mem_addr, base + 16'(2 * n_iss));
            n_iss++;
         end
         we     = is_d ? bus.d_cache_we : bus.i_cache_we;
         owe    = is_d ? bus.i_cache_we : bus.d_cache_we;
         stall  = is_d ? bus.d_stall    : bus.i_stall;
         ostall = is_d ? bus.i_stall    : bus.d_stall;
         req    = is_d ? bus.d_req      : bus.i_req;
         oreq   = is_d ? bus.i_req      : bus.d_req;
         ao     = is_d ? bus.d_addr_out : bus.i_addr_out;
         dat    = is_d ? bus.d_data     : bus.i_data;
         chk("other_we", owe, 0);
         chk("other_stall", ostall, oreq);
         if (we) begin
            ea = base + 16'(2 * n_rcv);
            chk($sformatf("fill_addr%0d", n_rcv), ao, ea);
            chk($sformatf("fill_data%0d", n_rcv), dat, fdat(ea));
            n_rcv++;
         end
         chk($sformatf("stall_c%0d", fidx), stall, req && !(we && n_rcv == WORDS));
         fidx++;
      end
      if (n_rcv < stop_rcv) chk("fill_timeout_words", n_rcv, stop_rcv);
      if (stop_rcv == WORDS) chk("issue_count", n_iss, WORDS);
   endtask

   task automatic idle_check(input string name);
      chk({name, "_mem_en"}, bus.mem_en, 0);
      chk({name, "_i_we"}, bus.i_cache_we, 0);
      chk({name, "_d_we"}, bus.d_cache_we, 0);
      chk({name, "_i_stall"}, bus.i_stall, 0);
      chk({name, "_d_stall"}, bus.d_stall, 0);
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      int nc;
      @(negedge clk);
      if (v.is_d && v.wr) begin
         bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
         #1;
         chk($sformatf("v%0d_arb_stall", idx), bus.d_stall, 1);
         chk($sformatf("v%0d_arb_mem_en", idx), bus.mem_en, 0);
         @(negedge clk); #1;
         chk($sformatf("v%0d_wr_en", idx), bus.mem_en, 1);
         chk($sformatf("v%0d_wr_wr", idx), bus.mem_wr, 1);
         chk($sformatf("v%0d_wr_addr", idx), bus.mem_addr, v.exp_base);
         chk($sformatf("v%0d_wr_data", idx), bus.mem_wdata, v.wdata);
         chk($sformatf("v%0d_wr_stall", idx), bus.d_stall, 0);
         chk($sformatf("v%0d_wr_dwe", idx), bus.d_cache_we, 0);
         chk($sformatf("v%0d_wr_iwe", idx), bus.i_cache_we, 0);
         @(negedge clk);
         bus.d_req = 1'b0; bus.d_wr = 1'b0;
         #1;
         chk($sformatf("v%0d_post_wr", idx), bus.mem_wr, 0);
         idle_check($sformatf("v%0d_post", idx));
      end else begin
         if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = v.addr;
         end else begin
            bus.i_req = 1'b1; bus.i_addr = v.addr;
         end
         watch_fill(v.is_d, v.exp_base, -1, WORDS, nc);
         chk($sformatf("v%0d_cycles", idx), nc, FILL_CYCLES);
         @(negedge clk);
         bus.i_req = 1'b0; bus.d_req = 1'b0;
         #1;
         idle_check($sformatf("v%0d_post", idx));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [6];
      vec_t fresh;
      vecs[0] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h0126, wdata: 16'h0000, exp_base: 16'h0120};
      vecs[1] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h4000, wdata: 16'hBEEF, exp_base: 16'h4000};
      vecs[2] = '{is_d: 1'b1, wr: 1'b0, addr: 16'hFFF4, wdata: 16'h0000, exp_base: 16'hFFF0};
      vecs[3] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h000F, wdata: 16'h0000, exp_base: 16'h0000};
      vecs[4] = '{is_d: 1'b1, wr: 1'b0, addr: 16'h3458, wdata: 16'h0000, exp_base: 16'h3450};
      vecs[5] = '{is_d: 1'b1, wr: 1'b1, addr: 16'hFFFF, wdata: 16'h1234, exp_base: 16'hFFFF};

      rst_n = 1'b0;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      idle_check("rst");
      chk("rst_mem_wr", bus.mem_wr, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_i_data", bus.i_data, 0);
      chk("rst_d_data", bus.d_data, 0);
      chk("rst_i_addr_out", bus.i_addr_out, 0);
      chk("rst_d_addr_out", bus.d_addr_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Both pending right after reset: D, then I (fairness), then D again.
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = 16'h0206;
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0312;
      watch_fill(1'b1, 16'h0310, -1, WORDS, cyc);
      chk("both_d1_cycles", cyc, FILL_CYCLES);
      @(negedge clk);
      watch_fill(1'b0, 16'h0200, -1, WORDS, cyc);
      chk("both_i_cycles", cyc, FILL_CYCLES);
      @(negedge clk);
      watch_fill(1'b1, 16'h0310, -1, WORDS, cyc);
      chk("both_d2_cycles", cyc, FILL_CYCLES);
      @(negedge clk);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      #1;
      idle_check("both_post");

      for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

      // Reset after three words of an I fill; late valids must be ignored.
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = 16'h0518;
      watch_fill(1'b0, 16'h0510, -1, 3, cyc);
      #1;
      rst_n = 1'b0;
      bus.i_req = 1'b0;
      #1;
      idle_check("midrst");
      chk("midrst_mem_addr", bus.mem_addr, 0);
      chk("midrst_i_data", bus.i_data, 0);
      chk("midrst_i_addr_out", bus.i_addr_out, 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 2) rst_n = 1'b1;
         #1;
         idle_check($sformatf("midrst_k%0d", k));
      end
      fresh = '{is_d: 1'b0, wr: 1'b0, addr: 16'h0A3C, wdata: 16'h0000, exp_base: 16'h0A30};
      run_txn(fresh, 10);

      // I request withdrawn in fill cycle 2: all words still written.
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = 16'h0744;
      watch_fill(1'b0, 16'h0740, 2, WORDS, cyc);
      chk("withdraw_cycles", cyc, FILL_CYCLES);
      chk("withdraw_req_low", bus.i_req, 0);
      @(negedge clk);
      #1;
      idle_check("withdraw_post");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
